// File: rtl/stack_op_sequencer.sv
// Command-port sequencer for the 8-bit hardware stack: turns PUSH/POP/TOP/ALU ops into
// stack push/pop pulse sequences, tracks occupancy and returns a one-cycle response.
module stack_op_sequencer #(
    parameter int DEPTH = 100,
    parameter int CW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [2:0]    op_code,
    input  logic [7:0]    op_data,
    output logic          resp_valid,
    output logic [7:0]    resp_data,
    output logic          resp_err,
    output logic [CW-1:0] count,
    output logic          stk_push,
    output logic          stk_pop,
    output logic          stk_tos,
    output logic [7:0]    stk_d_in,
    input  logic [7:0]    stk_d_out
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_ERR  = 4'd1;
    localparam logic [3:0] S_PSH  = 4'd2;
    localparam logic [3:0] S_POP1 = 4'd3;
    localparam logic [3:0] S_CAP  = 4'd4;
    localparam logic [3:0] S_POP2 = 4'd5;
    localparam logic [3:0] S_CALC = 4'd6;
    localparam logic [3:0] S_RPSH = 4'd7;
    localparam logic [3:0] S_RESP = 4'd8;

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_TOP  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] TWO_C   = CW'(2);

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    op_code_q, op_code_d;
    logic [7:0]    op_data_q, op_data_d;
    logic [7:0]    a_q, a_d;
    logic [7:0]    r_q, r_d;
    logic [7:0]    stk_d_in_q, stk_d_in_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_err_q, resp_err_d;
    logic [7:0]    resp_data_q, resp_data_d;

    // b is the entry below the top, a is the top entry
    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] b, input logic [7:0] a);
        logic [7:0] res;
        case (op)
            OP_ADD:  res = b + a;
            OP_SUB:  res = b - a;
            OP_AND:  res = b & a;
            OP_OR:   res = b | a;
            default: res = 8'h00;
        endcase
        return res;
    endfunction

    function automatic logic legal_f(input logic [2:0] op, input logic [CW-1:0] cnt);
        logic ok;
        case (op)
            OP_PUSH:                        ok = (cnt < DEPTH_C);
            OP_POP, OP_TOP:                 ok = (cnt >= ONE_C);
            OP_ADD, OP_SUB, OP_AND, OP_OR:  ok = (cnt >= TWO_C);
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Next-state, occupancy and response computation
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        op_code_d    = op_code_q;
        op_data_d    = op_data_q;
        a_d          = a_q;
        r_d          = r_q;
        stk_d_in_d   = stk_d_in_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_data_d  = resp_data_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    op_code_d = op_code;
                    op_data_d = op_data;
                    if (legal_f(op_code, count_q)) begin
                        if (op_code == OP_PUSH) begin
                            state_d    = S_PSH;
                            stk_d_in_d = op_data;
                        end else begin
                            state_d = S_POP1;
                        end
                    end else begin
                        state_d      = S_ERR;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = 8'h00;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            S_PSH: begin
                count_d      = count_q + ONE_C;
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_data_d  = op_data_q;
            end
            S_POP1: begin
                count_d = count_q - ONE_C;
                if ((op_code_q == OP_POP) || (op_code_q == OP_TOP)) begin
                    state_d = S_CAP;
                end else begin
                    state_d = S_POP2;
                end
            end
            S_CAP: begin
                r_d = stk_d_out;
                if (op_code_q == OP_TOP) begin
                    state_d    = S_RPSH;
                    stk_d_in_d = stk_d_out;
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_data_d  = stk_d_out;
                end
            end
            S_POP2: begin
                count_d = count_q - ONE_C;
                a_d     = stk_d_out;
                state_d = S_CALC;
            end
            S_CALC: begin
                r_d        = alu_f(op_code_q, stk_d_out, a_q);
                stk_d_in_d = alu_f(op_code_q, stk_d_out, a_q);
                state_d    = S_RPSH;
            end
            S_RPSH: begin
                count_d      = count_q + ONE_C;
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_data_d  = r_q;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            op_code_q    <= 3'b000;
            op_data_q    <= 8'h00;
            a_q          <= 8'h00;
            r_q          <= 8'h00;
            stk_d_in_q   <= 8'h00;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            op_code_q    <= op_code_d;
            op_data_q    <= op_data_d;
            a_q          <= a_d;
            r_q          <= r_d;
            stk_d_in_q   <= stk_d_in_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // The stack's tos port reads the head slot, not the top entry, so it stays unused
    assign stk_tos    = 1'b0;
    assign stk_push   = (state_q == S_PSH) || (state_q == S_RPSH);
    assign stk_pop    = (state_q == S_POP1) || (state_q == S_POP2);
    assign op_ready   = (state_q == S_IDLE);
    assign stk_d_in   = stk_d_in_q;
    assign count      = count_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed bench for stack_op_sequencer with a behavioural stack model and a response scoreboard.
module tb_stack_op_sequencer;

    localparam int DEPTH = 100;
    localparam int CW    = 10;

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_TOP  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [2:0]    op_code = 3'b000;
    logic [7:0]    op_data = 8'h00;
    logic          resp_valid;
    logic [7:0]    resp_data;
    logic          resp_err;
    logic [CW-1:0] count;
    logic          stk_push;
    logic          stk_pop;
    logic          stk_tos;
    logic [7:0]    stk_d_in;
    logic [7:0]    stk_d_out = 8'h00;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   push_cnt   = 0;
    int   pop_cnt    = 0;

    logic [7:0] mem [0:DEPTH-1];
    int         sp = 0;

    stack_op_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_data    (op_data),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .count      (count),
        .stk_push   (stk_push),
        .stk_pop    (stk_pop),
        .stk_tos    (stk_tos),
        .stk_d_in   (stk_d_in),
        .stk_d_out  (stk_d_out)
    );

    always #5 clk = ~clk;

    // Cycle counter used to timestamp expected responses
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stack: registered d_out, valid the cycle after a pop edge
    always @(posedge clk) begin
        if (rst) begin
            sp        <= 0;
            stk_d_out <= 8'h00;
        end else if (stk_push) begin
            push_cnt <= push_cnt + 1;
            if (sp < DEPTH) begin
                mem[sp] <= stk_d_in;
                sp      <= sp + 1;
            end
        end else if (stk_pop) begin
            pop_cnt <= pop_cnt + 1;
            if (sp > 0) begin
                stk_d_out <= mem[sp-1];
                sp        <= sp - 1;
            end
        end
    end

    // Response monitor: pops the scoreboard and checks data, error flag and timing
    always @(negedge clk) begin
        if (!rst) begin
            compared++;
            assert (stk_tos === 1'b0) else begin
                mismatched++;
                $error("FAIL stk_tos: observed %b expected 0", stk_tos);
            end
            compared++;
            assert ((stk_push & stk_pop) === 1'b0) else begin
                mismatched++;
                $error("FAIL push_pop_excl: observed push=%b pop=%b expected not both", stk_push, stk_pop);
            end
            if (resp_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $error("FAIL unexpected_resp: observed resp_valid=1 data=%0h expected no response", resp_data);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    compared++;
                    assert (resp_data === e.data) else begin
                        mismatched++;
                        $error("FAIL resp_data: observed %0h expected %0h", resp_data, e.data);
                    end
                    compared++;
                    assert (resp_err === e.err) else begin
                        mismatched++;
                        $error("FAIL resp_err: observed %b expected %b", resp_err, e.err);
                    end
                    compared++;
                    assert (cyc === e.cyc) else begin
                        mismatched++;
                        $error("FAIL resp_latency: observed cycle %0d expected cycle %0d", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (op_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_ready"}, 32'(op_ready), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [2:0] code, input logic [7:0] data,
                         input logic exp_err, input logic [7:0] exp_data, input int lat,
                         input int exp_cnt);
        exp_t e;
        int   k;
        wait_ready(tag);
        op_valid = 1'b1;
        op_code  = code;
        op_data  = data;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_code  = 3'b000;
        op_data  = 8'h00;
        e.err  = exp_err;
        e.data = exp_data;
        e.cyc  = cyc + lat - 1;
        sb_q.push_back(e);
        k = 0;
        while (sb_q.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_resp_seen"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        chk({tag, "_count"}, 32'(count), 32'(exp_cnt));
    endtask

    task automatic do_err(input string tag, input logic [2:0] code, input int exp_cnt);
        int p0;
        int q0;
        p0 = push_cnt;
        q0 = pop_cnt;
        do_op(tag, code, 8'h5A, 1'b1, 8'h00, 1, exp_cnt);
        chk({tag, "_no_push"}, 32'(push_cnt), 32'(p0));
        chk({tag, "_no_pop"}, 32'(pop_cnt), 32'(q0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] last_v;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_push", 32'(stk_push), 32'd0);
        chk("rst_pop", 32'(stk_pop), 32'd0);
        chk("rst_d_in", 32'(stk_d_in), 32'd0);

        do_op("push12", OP_PUSH, 8'h12, 1'b0, 8'h12, 2, 1);
        do_op("push34", OP_PUSH, 8'h34, 1'b0, 8'h34, 2, 2);
        do_op("pop34",  OP_POP,  8'h00, 1'b0, 8'h34, 3, 1);

        do_op("pushF0", OP_PUSH, 8'hF0, 1'b0, 8'hF0, 2, 2);
        do_op("push20", OP_PUSH, 8'h20, 1'b0, 8'h20, 2, 3);
        do_op("add",    OP_ADD,  8'h00, 1'b0, 8'h10, 5, 2);
        do_op("top",    OP_TOP,  8'h00, 1'b0, 8'h10, 4, 2);
        do_op("pop10",  OP_POP,  8'h00, 1'b0, 8'h10, 3, 1);
        do_op("pop12",  OP_POP,  8'h00, 1'b0, 8'h12, 3, 0);

        do_op("sub_p5", OP_PUSH, 8'h05, 1'b0, 8'h05, 2, 1);
        do_op("sub_p7", OP_PUSH, 8'h07, 1'b0, 8'h07, 2, 2);
        do_op("sub",    OP_SUB,  8'h00, 1'b0, 8'hFE, 5, 1);
        do_reset();
        do_op("and_p5", OP_PUSH, 8'h05, 1'b0, 8'h05, 2, 1);
        do_op("and_p7", OP_PUSH, 8'h07, 1'b0, 8'h07, 2, 2);
        do_op("and",    OP_AND,  8'h00, 1'b0, 8'h05, 5, 1);
        do_reset();
        do_op("or_p5",  OP_PUSH, 8'h05, 1'b0, 8'h05, 2, 1);
        do_op("or_p7",  OP_PUSH, 8'h07, 1'b0, 8'h07, 2, 2);
        do_op("or",     OP_OR,   8'h00, 1'b0, 8'h07, 5, 1);
        do_reset();

        do_err("empty_pop", OP_POP, 0);
        do_err("empty_top", OP_TOP, 0);
        do_err("empty_add", OP_ADD, 0);
        do_err("empty_rsv", OP_RSV, 0);
        do_op("one_push", OP_PUSH, 8'h55, 1'b0, 8'h55, 2, 1);
        do_err("one_add", OP_ADD, 1);
        do_reset();

        last_v = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            last_v = 8'(i * 3);
            do_op("fill", OP_PUSH, last_v, 1'b0, last_v, 2, i + 1);
        end
        do_err("full_push", OP_PUSH, DEPTH);
        do_op("full_pop", OP_POP, 8'h00, 1'b0, last_v, 3, DEPTH - 1);
        do_reset();

        do_op("abort_p1", OP_PUSH, 8'h01, 1'b0, 8'h01, 2, 1);
        do_op("abort_p2", OP_PUSH, 8'h02, 1'b0, 8'h02, 2, 2);
        wait_ready("abort_add");
        op_valid = 1'b1;
        op_code  = OP_ADD;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_code  = 3'b000;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_pop2", 32'(stk_pop), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_count", 32'(count), 32'd0);
        chk("abort_ready", 32'(op_ready), 32'd1);
        chk("abort_no_resp", 32'(resp_valid), 32'd0);
        repeat (8) @(negedge clk);
        do_err("abort_pop", OP_POP, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
